// File: rtl/sdfake_mem_arbiter_if.sv
// Emulator read port, loader write port and single-port RAM port of the card-image arbiter.
// master = arbiter side, slave = emulator/loader/RAM side.
interface sdfake_mem_arbiter_if #(
   parameter int AW = 12,
   parameter int DW = 8
);
   logic          rd_req;
   logic [63:0]   rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_oob;

   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   modport master (
      input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
      output rd_data, rd_oob, wr_ready, ram_en, ram_we, ram_addr, ram_wdata
   );

   modport slave (
      output rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
      input  rd_data, rd_oob, wr_ready, ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/sdfake_mem_arbiter.sv
// Shares one single-port byte RAM between the SD-emulator read port and a host loader write port.
// Latency: read data 1 cycle after rd_req, held until the next read; RAM cleared after every reset.
// Backpressure: reads always win; wr_ready drops in any cycle with rd_req or outside RUN.
module sdfake_mem_arbiter #(
   parameter int            AW       = 12,
   parameter int            DW       = 8,
   parameter logic [DW-1:0] INIT_VAL = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sdfake_mem_arbiter_if.master bus,
   output logic                 init_done,
   output logic [15:0]          wr_stall_cnt
);
   typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] init_cnt;
   logic          rd_in_range;
   logic          rd_ram;
   logic          wr_fire;
   logic          rd_pend;
   logic [DW-1:0] rd_hold;

   assign rd_in_range  = (bus.rd_addr[63:AW] == '0);
   assign rd_ram       = bus.rd_req && rd_in_range && (state == RUN);
   assign bus.wr_ready = (state == RUN) && !bus.rd_req;
   assign wr_fire      = bus.wr_valid && bus.wr_ready;
   assign init_done    = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         init_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == INIT)
            init_cnt <= init_cnt + 1'b1;
      end
   end

   // Sweep owns the RAM during INIT; afterwards an in-range read pre-empts any write.
   always_comb begin
      state_nxt     = state;
      bus.ram_en    = 1'b0;
      bus.ram_we    = 1'b0;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      unique case (state)
         IDLE: state_nxt = INIT;
         INIT: begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = 1'b1;
            bus.ram_addr  = init_cnt;
            bus.ram_wdata = INIT_VAL;
            if (init_cnt == '1)
               state_nxt = RUN;
         end
         RUN: begin
            if (rd_ram) begin
               bus.ram_en   = 1'b1;
               bus.ram_addr = bus.rd_addr[AW-1:0];
            end else if (wr_fire) begin
               bus.ram_en    = 1'b1;
               bus.ram_we    = 1'b1;
               bus.ram_addr  = bus.wr_addr;
               bus.ram_wdata = bus.wr_data;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A newer request overrides capture of the previous RAM word into the hold register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend    <= 1'b0;
         rd_hold    <= INIT_VAL;
         bus.rd_oob <= 1'b0;
      end else begin
         rd_pend    <= rd_ram;
         bus.rd_oob <= bus.rd_req && !rd_in_range;
         if (bus.rd_req && !rd_ram)
            rd_hold <= INIT_VAL;
         else if (rd_pend)
            rd_hold <= bus.ram_rdata;
      end
   end

   assign bus.rd_data = rd_pend ? bus.ram_rdata : rd_hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wr_stall_cnt <= '0;
      else if ((state == RUN) && bus.wr_valid && !bus.wr_ready && (wr_stall_cnt != 16'hFFFF))
         wr_stall_cnt <= wr_stall_cnt + 16'd1;
   end
endmodule
